// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver (8 data bits LSB first, one start bit, one stop bit, no parity).
// The serial line passes through a two-flop synchroniser. A start bit must still be low at
// mid-bit or it is treated as a glitch. Each data bit and the stop bit are sampled at mid-bit.
// A good frame produces a one-cycle valid strobe. A low stop bit produces a one-cycle framing
// error strobe; the receiver then waits for the line to return high.
//
// Parameters:
//   CLKS_PER_BIT    clock cycles per serial bit (legal range 4..255)
// Ports:
//   i_Clock         system clock, rising edge
//   i_Rst_L         asynchronous active-low reset
//   i_Rx_Serial     asynchronous serial input, idles high
//   o_Rx_DV         one-cycle pulse, o_Rx_Byte valid with it
//   o_Rx_Byte       last correctly framed byte, held until the next good byte
//   o_Rx_Frame_Err  one-cycle pulse when the stop bit samples low
//   o_Rx_Active     high while a frame is in progress (start, data and stop bits)
`timescale 1ns / 1ps

module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 87
) (
    input  logic       i_Clock,
    input  logic       i_Rst_L,
    input  logic       i_Rx_Serial,
    output logic       o_Rx_DV,
    output logic [7:0] o_Rx_Byte,
    output logic       o_Rx_Frame_Err,
    output logic       o_Rx_Active
);

    localparam logic [7:0] HalfCnt = 8'((CLKS_PER_BIT - 1) / 2);
    localparam logic [7:0] LastCnt = 8'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StStart   = 3'd1,
        StData    = 3'd2,
        StStop    = 3'd3,
        StCleanup = 3'd4,
        StBreak   = 3'd5
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] byte_q, byte_d;
    logic       dv_q, dv_d;
    logic       err_q, err_d;

    // Two-flop synchroniser; both stages reset to the idle (high) level.
    logic       rx_meta_q;
    logic       rx_sync_q;

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= i_Rx_Serial;
            rx_sync_q <= rx_meta_q;
        end
    end

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q <= StIdle;
            cnt_q   <= 8'd0;
            idx_q   <= 3'd0;
            shift_q <= 8'd0;
            byte_q  <= 8'd0;
            dv_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            byte_q  <= byte_d;
            dv_q    <= dv_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        byte_d  = byte_q;
        dv_d    = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            StIdle: begin
                cnt_d = 8'd0;
                idx_d = 3'd0;
                if (!rx_sync_q) begin
                    state_d = StStart;
                end
            end

            // Re-check the start bit at its middle; a high line here was a glitch.
            StStart: begin
                if (cnt_q == HalfCnt) begin
                    cnt_d   = 8'd0;
                    state_d = rx_sync_q ? StIdle : StData;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            // Counter is now phase-aligned to mid-bit, so a full bit period lands mid-bit.
            StData: begin
                if (cnt_q == LastCnt) begin
                    cnt_d          = 8'd0;
                    shift_d[idx_q] = rx_sync_q;
                    if (idx_q == 3'd7) begin
                        idx_d   = 3'd0;
                        state_d = StStop;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            StStop: begin
                if (cnt_q == LastCnt) begin
                    cnt_d = 8'd0;
                    if (rx_sync_q) begin
                        byte_d  = shift_q;
                        dv_d    = 1'b1;
                        state_d = StCleanup;
                    end else begin
                        err_d   = 1'b1;
                        state_d = StBreak;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            StCleanup: begin
                state_d = StIdle;
            end

            // Wait out a held-low line so a break reports a single framing error.
            StBreak: begin
                if (rx_sync_q) begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
                cnt_d   = 8'd0;
                idx_d   = 3'd0;
            end
        endcase
    end

    assign o_Rx_DV        = dv_q;
    assign o_Rx_Byte      = byte_q;
    assign o_Rx_Frame_Err = err_q;
    assign o_Rx_Active    = (state_q == StStart) || (state_q == StData) || (state_q == StStop);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx at CLKS_PER_BIT = 8.
// Frames are driven bit by bit; a scoreboard queue holds the bytes that must come out and a
// counter holds the framing errors that must be reported.
`timescale 1ns / 1ps

module tb_uart_rx;

    localparam int unsigned C    = 8;
    localparam int unsigned HALF = (C - 1) / 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_line;
    logic       dv;
    logic [7:0] rx_byte;
    logic       ferr;
    logic       active;

    uart_rx #(
        .CLKS_PER_BIT(C)
    ) dut (
        .i_Clock       (clk),
        .i_Rst_L       (rst_n),
        .i_Rx_Serial   (rx_line),
        .o_Rx_DV       (dv),
        .o_Rx_Byte     (rx_byte),
        .o_Rx_Frame_Err(ferr),
        .o_Rx_Active   (active)
    );

    always #5 clk = ~clk;

    // Number of rising edges seen so far.
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    // Monitor: sampled on the falling edge, away from the active edge.
    logic [7:0]  rx_q[$];
    int unsigned err_cnt  = 0;
    int unsigned both_cnt = 0;
    always @(negedge clk) begin
        if (dv) rx_q.push_back(rx_byte);
        if (ferr) err_cnt++;
        if (dv && ferr) both_cnt++;
    end

    // Reference model state.
    logic [7:0]  exp_q[$];
    int unsigned exp_err = 0;
    int unsigned t0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // All driving code stays aligned to 1 ns after a rising edge.
    task automatic hold(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int unsigned t);
        do @(negedge clk); while (cyc < t);
    endtask

    // Drives one frame; t0 is the edge that first captures the start bit.
    task automatic send_frame(input logic [7:0] data, input logic stop);
        t0      = cyc + 1;
        rx_line = 1'b0;
        hold(C);
        for (int i = 0; i < 8; i++) begin
            rx_line = data[i];
            hold(C);
        end
        rx_line = stop;
        hold(C);
    endtask

    task automatic compare_all(input string tag);
        check_eq({tag, "_count"}, rx_q.size(), exp_q.size());
        while (rx_q.size() > 0 && exp_q.size() > 0) begin
            check_eq({tag, "_byte"}, rx_q.pop_front(), exp_q.pop_front());
        end
        rx_q.delete();
        exp_q.delete();
        check_eq({tag, "_ferr"}, err_cnt, exp_err);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        logic       good;
        logic [7:0] last_good;

        rst_n   = 1'b0;
        rx_line = 1'b1;
        #1;
        check_eq("rst_dv", dv, 0);
        check_eq("rst_ferr", ferr, 0);
        check_eq("rst_active", active, 0);
        check_eq("rst_byte", rx_byte, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        hold(4);

        // Single frame with exact latency checks.
        fork
            send_frame(8'hA5, 1'b1);
            begin
                #2;
                wait_cyc(t0 + 1);
                check_eq("a5_active_pre", active, 0);
                wait_cyc(t0 + 2);
                check_eq("a5_active_rise", active, 1);
                wait_cyc(t0 + 3 + HALF + 9 * C - 1);
                check_eq("a5_active_late", active, 1);
                check_eq("a5_dv_early", dv, 0);
                wait_cyc(t0 + 3 + HALF + 9 * C);
                check_eq("a5_dv", dv, 1);
                check_eq("a5_byte", rx_byte, 8'hA5);
                check_eq("a5_active_fall", active, 0);
                wait_cyc(t0 + 3 + HALF + 9 * C + 1);
                check_eq("a5_dv_width", dv, 0);
            end
        join
        exp_q.push_back(8'hA5);
        compare_all("a5");

        // Short glitch, then a real frame.
        rx_line = 1'b0;
        hold(2);
        rx_line = 1'b1;
        hold(3 * C);
        check_eq("glitch_active", active, 0);
        compare_all("glitch");
        send_frame(8'h5A, 1'b1);
        hold(2);
        exp_q.push_back(8'h5A);
        compare_all("5a");

        // Bad stop bit followed by a long break.
        send_frame(8'h3C, 1'b0);
        hold(20 * C);
        exp_err++;
        check_eq("brk_byte_held", rx_byte, 8'h5A);
        rx_line = 1'b1;
        hold(2 * C);
        compare_all("break");
        send_frame(8'h81, 1'b1);
        hold(2);
        exp_q.push_back(8'h81);
        compare_all("81");

        // Back-to-back frames with no idle gap.
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h55, 1'b1);
        hold(2);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h55);
        compare_all("b2b");

        // Randomized frames with random gaps and occasional bad stop bits.
        last_good = 8'h55;
        for (int k = 0; k < 16; k++) begin
            d    = 8'($urandom_range(0, 255));
            good = ($urandom_range(0, 3) != 0);
            hold($urandom_range(0, 3));
            send_frame(d, good);
            if (good) begin
                exp_q.push_back(d);
                last_good = d;
            end else begin
                exp_err++;
                rx_line = 1'b1;
                hold(2 * C);
            end
        end
        hold(2);
        compare_all("rand");
        check_eq("rand_byte_held", rx_byte, last_good);

        // Reset in the middle of data bit 3.
        fork
            send_frame(8'h96, 1'b1);
            begin
                #2;
                wait_cyc(t0 + 4 * C + 3);
                check_eq("mid_active", active, 1);
                #1;
                rst_n = 1'b0;
                #1;
                check_eq("mid_rst_active", active, 0);
                check_eq("mid_rst_byte", rx_byte, 0);
                check_eq("mid_rst_dv", dv, 0);
                check_eq("mid_rst_ferr", ferr, 0);
            end
        join
        rst_n = 1'b1;
        hold(2 * C);
        compare_all("midrst");
        send_frame(8'hC3, 1'b1);
        hold(2);
        exp_q.push_back(8'hC3);
        compare_all("c3");

        check_eq("dv_ferr_overlap", both_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
